// File: rtl/seq_det_param.sv
// Parametrised serial bit-pattern detector with run-time reloadable pattern/mask,
// overlapping or non-overlapping detection, and a saturating match counter.
module seq_det_param #(
   parameter int unsigned   W         = 4,
   parameter logic [W-1:0]  RESET_PAT = 4'b0110,
   parameter int unsigned   CW        = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic          in,
   input  logic          pat_load,
   input  logic [W-1:0]  pat_in,
   input  logic [W-1:0]  mask_in,
   input  logic          overlap_en,
   output logic          out,
   output logic [CW-1:0] match_cnt,
   output logic          cnt_sat
);

   localparam int unsigned   FW        = $clog2(W + 1);
   localparam logic [FW-1:0] FILL_FULL = FW'(W);
   localparam logic [CW-1:0] CNT_MAX   = '1;

   logic [W-1:0]  pat_q, pat_d;
   logic [W-1:0]  mask_q, mask_d;
   logic [W-1:0]  hist_q, hist_d;
   logic [FW-1:0] fill_q, fill_d;
   logic          out_q, out_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sat_q, sat_d;

   logic [W-1:0]  nh;
   logic [FW-1:0] nf;
   logic          hit;

   // Next-state: reload beats a consumed bit; idle cycles hold history and drop the pulse.
   always_comb begin
      pat_d  = pat_q;
      mask_d = mask_q;
      hist_d = hist_q;
      fill_d = fill_q;
      out_d  = 1'b0;
      cnt_d  = cnt_q;
      sat_d  = sat_q;

      nh  = {hist_q[W-2:0], in};
      nf  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FW'(1);
      hit = (nf == FILL_FULL) && (((nh ^ pat_q) & mask_q) == '0);

      if (pat_load) begin
         pat_d  = pat_in;
         mask_d = mask_in;
         hist_d = '0;
         fill_d = '0;
         cnt_d  = '0;
         sat_d  = 1'b0;
      end else if (in_valid) begin
         hist_d = nh;
         out_d  = hit;
         // Non-overlap mode discards the matched bits so the next match needs W fresh ones.
         fill_d = (hit && !overlap_en) ? '0 : nf;
         if (hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
         end
         sat_d = sat_q | (cnt_d == CNT_MAX);
      end
   end

   // State registers with asynchronous reset to the power-on pattern.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_q  <= RESET_PAT;
         mask_q <= '1;
         hist_q <= '0;
         fill_q <= '0;
         out_q  <= 1'b0;
         cnt_q  <= '0;
         sat_q  <= 1'b0;
      end else begin
         pat_q  <= pat_d;
         mask_q <= mask_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         out_q  <= out_d;
         cnt_q  <= cnt_d;
         sat_q  <= sat_d;
      end
   end

   assign out       = out_q;
   assign match_cnt = cnt_q;
   assign cnt_sat   = sat_q;

endmodule
